cache_refill: RTL and testbench
===============================

CACHE_REFILL -- requirements
Module: cache_refill

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning width of one RAM word and memory beat.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, meaning RAM word-index width.
REQ-003 SHALL have parameter DATA_BYTE_NUM, default 4, meaning byte-enable width; DATA_WIDTH = 8*DATA_BYTE_NUM.
REQ-004 SHALL have parameter LINE_WORDS, default 4, meaning beats per line (power of two, 2..2^ADDR_WIDTH).
REQ-005 SHALL have parameter MEM_ADDR_WIDTH, default 32, meaning memory byte-address width.
REQ-006 SHALL have clk input 1 bit: the single clock; all state changes on posedge clk.
REQ-007 SHALL have rst_n input 1 bit: asynchronous, active-low reset.
REQ-008 req_valid input 1 / req_ready output 1: miss-refill request handshake.
REQ-009 req_addr input MEM_ADDR_WIDTH: byte address of missing access.
REQ-010 req_ram_base input ADDR_WIDTH: RAM index of the line's first word.
REQ-011 mem_rd_valid output 1 / mem_rd_ready input 1: memory burst-read command handshake.
REQ-012 mem_rd_addr output MEM_ADDR_WIDTH: line-aligned burst start address.
REQ-013 mem_resp_valid input 1 / mem_resp_data input DATA_WIDTH: returned beats, in order, no backpressure.
REQ-014 ram_wr_en output 1, ram_wr_addr output ADDR_WIDTH, ram_wr_data output DATA_WIDTH, ram_wr_byte_en output DATA_BYTE_NUM: write port of downstream cache RAM.
REQ-015 busy output 1: refill in progress; done output 1: one-cycle completion pulse.

Function
REQ-016 FSM states IDLE, CMD, FILL, DONE; encoding is implementer's choice.
REQ-017 IDLE: req_ready=1; req_valid&req_ready latches req_addr/req_ram_base, goes to CMD next cycle.
REQ-018 CMD: mem_rd_valid=1, mem_rd_addr = req_addr with low log2(LINE_WORDS)+log2(DATA_BYTE_NUM) bits zeroed; held stable until mem_rd_ready; on handshake beat counter cleared, go to FILL.
REQ-019 FILL: each mem_resp_valid cycle accepts one beat; counter increments by 1.
REQ-020 Each accepted beat k produces, registered, exactly one cycle later: ram_wr_en=1, ram_wr_addr=(base+k) mod 2^ADDR_WIDTH, ram_wr_data=beat, ram_wr_byte_en=all ones.
REQ-021 Beat LINE_WORDS-1 accepted -> DONE; in DONE, done=1 for one cycle coincident with last ram_wr_en; then IDLE.
REQ-022 busy=1 in CMD, FILL, DONE; req_ready=0 in those states; no request queueing.
REQ-023 mem_resp_valid outside FILL SHALL be ignored (no RAM write, no state change).
REQ-024 ram_wr_en=0 in every cycle not following an accepted beat; byte_en/addr/data don't-care then.
REQ-025 Minimum latency req handshake to done: 3 cycles + memory latency + LINE_WORDS beats back-to-back.
REQ-026 RAM index wrap-around at 2^ADDR_WIDTH SHALL be silent modulo wrap.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, counter 0, and outputs req_ready=1 (after release), mem_rd_valid=0, ram_wr_en=0, done=0, busy=0.
REQ-028 Reset mid-FILL SHALL abandon the line without done; partially written RAM words remain.
REQ-029 rst_n deassertion SHALL take effect at next posedge clk; no datapath register requires reset.

Structure
REQ-030 A shared cache package SHALL hold the FSM state enum and line-offset width constants (log2 LINE_WORDS, log2 DATA_BYTE_NUM).
REQ-031 No sub-module; beat counter and FSM are inline.

Verification
REQ-032 req_addr=0x0000_1234, base=8, mem_rd_ready same cycle, beats A0..A3 back-to-back -> mem_rd_addr=0x0000_1230; writes idx 8,9,10,11 data A0..A3 byte_en=4'hF; done with idx 11 write.
REQ-033 base=30, LINE_WORDS=4 -> writes to idx 30,31,0,1.
REQ-034 mem_rd_ready held low 5 cycles -> mem_rd_valid and mem_rd_addr stable throughout; no RAM write until handshake.
REQ-035 Beats with gaps (valid 1,0,0,1,1,0,1) -> exactly four writes, each one cycle after its beat, done once.
REQ-036 rst_n pulsed low after second beat -> no further writes, no done, busy=0, next request completes normally.
REQ-037 req_valid during busy, stray mem_resp_valid in IDLE -> req_ready=0 not accepted; stray beat causes no write.

Source files
------------

// File: rtl/cache_refill_pkg.sv
// Shared cache definitions: refill FSM states and line-offset widths.
package cache_refill_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CMD,
      ST_FILL,
      ST_DONE
   } state_e;

   localparam int unsigned LINE_WORDS_DFLT = 4;
   localparam int unsigned BYTE_NUM_DFLT   = 4;
   localparam int unsigned LINE_OFF_W      = $clog2(LINE_WORDS_DFLT);
   localparam int unsigned BYTE_OFF_W      = $clog2(BYTE_NUM_DFLT);

   function automatic int unsigned line_off_bits(
      input int unsigned words,
      input int unsigned bytes
   );
      return $clog2(words) + $clog2(bytes);
   endfunction

endpackage

// File: rtl/cache_refill.sv
// Cache line refill engine: issues one burst read per miss and
// streams the returned beats into the cache RAM write port.
module cache_refill
   import cache_refill_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 5,
   parameter int DATA_BYTE_NUM  = BYTE_NUM_DFLT,
   parameter int LINE_WORDS     = LINE_WORDS_DFLT,
   parameter int MEM_ADDR_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [MEM_ADDR_WIDTH-1:0] req_addr,
   input  logic [ADDR_WIDTH-1:0]     req_ram_base,
   output logic                      mem_rd_valid,
   input  logic                      mem_rd_ready,
   output logic [MEM_ADDR_WIDTH-1:0] mem_rd_addr,
   input  logic                      mem_resp_valid,
   input  logic [DATA_WIDTH-1:0]     mem_resp_data,
   output logic                      ram_wr_en,
   output logic [ADDR_WIDTH-1:0]     ram_wr_addr,
   output logic [DATA_WIDTH-1:0]     ram_wr_data,
   output logic [DATA_BYTE_NUM-1:0]  ram_wr_byte_en,
   output logic                      busy,
   output logic                      done
);

   localparam int OFF_W = int'(line_off_bits(LINE_WORDS, DATA_BYTE_NUM));
   localparam int CNT_W = $clog2(LINE_WORDS);
   localparam logic [MEM_ADDR_WIDTH-1:0] OFF_MASK =
      MEM_ADDR_WIDTH'((64'd1 << OFF_W) - 64'd1);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);

   state_e                    state_q;
   logic [CNT_W-1:0]          cnt_q;
   logic                      req_ready_q;
   logic                      rd_valid_q;
   logic                      busy_q;
   logic                      done_q;
   logic                      wr_en_q;
   logic [MEM_ADDR_WIDTH-1:0] addr_q;
   logic [ADDR_WIDTH-1:0]     base_q;
   logic [ADDR_WIDTH-1:0]     wr_addr_q;
   logic [DATA_WIDTH-1:0]     wr_data_q;

   logic req_fire;
   logic beat_fire;

   assign req_fire  = (state_q == ST_IDLE) && req_valid;
   assign beat_fire = (state_q == ST_FILL) && mem_resp_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         req_ready_q <= 1'b1;
         rd_valid_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         wr_en_q     <= 1'b0;
      end else begin
         wr_en_q <= 1'b0;
         done_q  <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  state_q     <= ST_CMD;
                  req_ready_q <= 1'b0;
                  rd_valid_q  <= 1'b1;
                  busy_q      <= 1'b1;
               end
            end
            ST_CMD: begin
               if (mem_rd_ready) begin
                  state_q    <= ST_FILL;
                  rd_valid_q <= 1'b0;
                  cnt_q      <= '0;
               end
            end
            ST_FILL: begin
               if (mem_resp_valid) begin
                  wr_en_q <= 1'b1;
                  cnt_q   <= cnt_q + CNT_W'(1);
                  // done lines up with the write of the final beat
                  if (cnt_q == LAST_BEAT) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               state_q     <= ST_IDLE;
               req_ready_q <= 1'b1;
               busy_q      <= 1'b0;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (req_fire) begin
         addr_q <= req_addr & ~OFF_MASK;
         base_q <= req_ram_base;
      end
      if (beat_fire) begin
         wr_addr_q <= base_q + ADDR_WIDTH'(cnt_q);
         wr_data_q <= mem_resp_data;
      end
   end

   assign req_ready      = req_ready_q;
   assign mem_rd_valid   = rd_valid_q;
   assign mem_rd_addr    = addr_q;
   assign ram_wr_en      = wr_en_q;
   assign ram_wr_addr    = wr_addr_q;
   assign ram_wr_data    = wr_data_q;
   assign ram_wr_byte_en = '1;
   assign busy           = busy_q;
   assign done           = done_q;

endmodule

// File: tb/tb_cache_refill.sv
// Randomized bench for cache_refill against a cycle-window and
// write-queue reference model.
module tb_cache_refill;

   localparam int DW   = 32;
   localparam int AW   = 5;
   localparam int BN   = 4;
   localparam int LW   = 4;
   localparam int MAW  = 32;
   localparam int HUGE = 32'h7fff_ffff;
   localparam int LINE_BYTES = LW * BN;

   logic           clk;
   logic           rst_n;
   logic           req_valid;
   logic           req_ready;
   logic [MAW-1:0] req_addr;
   logic [AW-1:0]  req_ram_base;
   logic           mem_rd_valid;
   logic           mem_rd_ready;
   logic [MAW-1:0] mem_rd_addr;
   logic           mem_resp_valid;
   logic [DW-1:0]  mem_resp_data;
   logic           ram_wr_en;
   logic [AW-1:0]  ram_wr_addr;
   logic [DW-1:0]  ram_wr_data;
   logic [BN-1:0]  ram_wr_byte_en;
   logic           busy;
   logic           done;

   cache_refill #(
      .DATA_WIDTH     (DW),
      .ADDR_WIDTH     (AW),
      .DATA_BYTE_NUM  (BN),
      .LINE_WORDS     (LW),
      .MEM_ADDR_WIDTH (MAW)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_addr       (req_addr),
      .req_ram_base   (req_ram_base),
      .mem_rd_valid   (mem_rd_valid),
      .mem_rd_ready   (mem_rd_ready),
      .mem_rd_addr    (mem_rd_addr),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data),
      .ram_wr_en      (ram_wr_en),
      .ram_wr_addr    (ram_wr_addr),
      .ram_wr_data    (ram_wr_data),
      .ram_wr_byte_en (ram_wr_byte_en),
      .busy           (busy),
      .done           (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(
      input string       tag,
      input logic [63:0] got,
      input logic [63:0] exp
   );
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   typedef struct {
      int            due;
      logic [AW-1:0] idx;
      logic [DW-1:0] data;
   } wr_t;

   wr_t            wq[$];
   int             b_from   = HUGE;
   int             b_to     = HUGE;
   int             c_from   = HUGE;
   int             c_to     = HUGE;
   int             done_due = -1;
   logic [MAW-1:0] exp_rd_addr;

   always @(negedge clk) begin
      logic exp_busy;
      logic exp_cmd;
      logic exp_wr;
      exp_busy = (cyc >= b_from) && (cyc <= b_to);
      exp_cmd  = (cyc >= c_from) && (cyc <= c_to);
      exp_wr   = (wq.size() > 0) && (wq[0].due == cyc);
      chk("busy", {63'd0, busy}, {63'd0, exp_busy});
      chk("req_ready", {63'd0, req_ready}, {63'd0, !exp_busy});
      chk("rd_valid", {63'd0, mem_rd_valid}, {63'd0, exp_cmd});
      if (exp_cmd)
         chk("rd_addr", 64'(mem_rd_addr), 64'(exp_rd_addr));
      chk("wr_en", {63'd0, ram_wr_en}, {63'd0, exp_wr});
      if (exp_wr) begin
         if (ram_wr_en) begin
            chk("wr_addr", 64'(ram_wr_addr), 64'(wq[0].idx));
            chk("wr_data", 64'(ram_wr_data), 64'(wq[0].data));
            chk("wr_be", 64'(ram_wr_byte_en), 64'({BN{1'b1}}));
         end
         void'(wq.pop_front());
      end
      chk("done", {63'd0, done}, {63'd0, cyc == done_due});
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      wq.delete();
      b_from   = HUGE;
      b_to     = HUGE;
      c_from   = HUGE;
      c_to     = HUGE;
      done_due = -1;
   endtask

   // mode 0: back-to-back beats, 1: fixed gap pattern, 2: random gaps
   task automatic refill(
      input logic [MAW-1:0] addr,
      input logic [AW-1:0]  base,
      input int             delay,
      input int             mode,
      input bit             dseq,
      input logic [DW-1:0]  d0,
      input int             abort_at
   );
      logic           pat [7];
      logic           v;
      logic [DW-1:0]  d;
      int             k;
      int             g;
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      req_valid      = 1'b1;
      req_addr       = addr;
      req_ram_base   = base;
      mem_resp_valid = 1'b0;
      mem_rd_ready   = 1'b0;
      exp_rd_addr    = (addr / LINE_BYTES) * LINE_BYTES;
      b_from = cyc + 1;
      b_to   = HUGE;
      c_from = cyc + 1;
      c_to   = HUGE;
      step();
      req_valid    = 1'b0;
      req_addr     = $urandom;
      req_ram_base = AW'($urandom);
      for (int i = 0; i < delay; i++) begin
         mem_resp_valid = 1'($urandom);
         mem_resp_data  = $urandom;
         req_valid      = 1'($urandom);
         step();
      end
      mem_rd_ready   = 1'b1;
      mem_resp_valid = 1'($urandom);
      req_valid      = 1'($urandom);
      c_to = cyc;
      step();
      mem_rd_ready = 1'b0;
      k = 0;
      g = 0;
      while (k < LW) begin
         if (mode == 0)      v = 1'b1;
         else if (mode == 1) v = pat[g % 7];
         else                v = ($urandom_range(2) != 0);
         g++;
         d = dseq ? d0 + DW'(k) : DW'($urandom);
         mem_resp_valid = v;
         mem_resp_data  = d;
         req_valid      = 1'($urandom);
         if (v) begin
            wq.push_back('{cyc + 1, AW'((int'(base) + k) % (1 << AW)), d});
            if (k == LW - 1) begin
               b_to     = cyc + 1;
               done_due = cyc + 1;
            end
            k++;
         end
         step();
         if (abort_at != 0 && k == abort_at) begin
            mem_resp_valid = 1'b0;
            req_valid      = 1'b0;
            step();
            rst_n = 1'b0;
            model_reset();
            step();
            step();
            rst_n = 1'b1;
            return;
         end
      end
      mem_resp_valid = 1'b0;
      req_valid      = 1'b0;
      step();
      mem_resp_valid = 1'b1;
      mem_resp_data  = $urandom;
      step();
      mem_resp_valid = 1'b0;
   endtask

   initial begin
      rst_n          = 1'b1;
      req_valid      = 1'b0;
      req_addr       = '0;
      req_ram_base   = '0;
      mem_rd_ready   = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      #2 rst_n = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      step();

      refill(32'h0000_1234, 5'd8, 0, 0, 1'b1, 32'hA0, 0);
      refill(32'h0000_2200, 5'd30, 0, 0, 1'b0, '0, 0);
      refill(32'h0000_345C, 5'd3, 5, 0, 1'b0, '0, 0);
      refill(32'h0000_4008, 5'd12, 1, 1, 1'b0, '0, 0);
      refill(32'h0000_5004, 5'd20, 0, 0, 1'b0, '0, 2);
      step();
      chk("busy_after_abort", {63'd0, busy}, 64'd0);
      refill(32'h0000_6010, 5'd16, 2, 0, 1'b0, '0, 0);

      for (int n = 0; n < 20; n++)
         refill($urandom, AW'($urandom), $urandom_range(4), 2, 1'b0, '0, 0);

      repeat (3) step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
